// File: rtl/rm_lane_manager_pkg.sv
// Shared types and opcode decode for the runtime-monitor lane allocator.
// Combinational helpers only; no state, no backpressure.
// Class enables are indexed by rm_class_e.
package rm_lane_manager_pkg;

    localparam int VLEN = 64;

    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        CLS_STORE  = 2'd0,
        CLS_LOAD   = 2'd1,
        CLS_BRANCH = 2'd2,
        CLS_JUMP   = 2'd3
    } rm_class_e;

    function automatic logic opcode_class_en(input logic [6:0] opcode, input logic [3:0] class_en);
        logic hit;
        hit = 1'b0;
        case (opcode)
            OPC_STORE:          hit = class_en[CLS_STORE];
            OPC_LOAD:           hit = class_en[CLS_LOAD];
            OPC_BRANCH:         hit = class_en[CLS_BRANCH];
            OPC_JAL, OPC_JALR:  hit = class_en[CLS_JUMP];
            default:            hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/rm_lane_manager_picker.sv
// Picks the first set bit of avail scanning upward from start, wrapping at N.
// Purely combinational, zero latency.
// No backpressure; found=0 when avail is empty.
module rm_lane_manager_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         avail,
    input  logic [$clog2(N)-1:0] start,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    function automatic int wrap(input int v);
        return (v >= N) ? v - N : v;
    endfunction

    // Scan from the far end so the closest candidate to start is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (avail[wrap(int'(start) + k)]) begin
                found = 1'b1;
                idx   = IW'(wrap(int'(start) + k));
            end
        end
    end

endmodule

// File: rtl/rm_lane_manager.sv
// Allocates monitor lanes to issuing instructions, frees them on release events or watchdog expiry.
// Grant is combinational (0 cycles); lane state updates at the next edge.
// When no lane is free the instruction is either stalled or issued unmonitored and counted.
module rm_lane_manager
    import rm_lane_manager_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int NUM_EVENTS   = 10,
    parameter int ALLOC_POLICY = 0,
    parameter int FULL_MODE    = 0,
    parameter int TIMEOUT      = 1024,
    parameter int DROP_CNT_W   = 16
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,
    input  logic [6:0]                                   opcode_i,
    input  logic [VLEN-1:0]                              pc_i,
    input  logic                                         entry_queued_i,
    input  logic                                         flush_i,
    input  logic [3:0]                                   cfg_class_en_i,
    input  logic [NUM_EVENTS*($clog2(NUM_LANES)+1)-1:0]  rel_i,
    output logic [$clog2(NUM_LANES)+VLEN:0]              monitor_o,
    output logic                                         stall_o,
    output logic                                         drop_o,
    output logic                                         timeout_o,
    output logic [$clog2(NUM_LANES)-1:0]                 timeout_lane_o,
    output logic [$clog2(NUM_LANES+1)-1:0]               occupancy_o,
    output logic [DROP_CNT_W-1:0]                        drop_cnt_o
);

    localparam int LW = $clog2(NUM_LANES);
    localparam int OW = $clog2(NUM_LANES + 1);
    localparam int AW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [AW-1:0] AGE_LAST = AW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef struct packed {
        logic          reset_lane;
        logic [LW-1:0] lane;
    } lane_ctrl_t;

    typedef struct packed {
        logic            monitor_ins;
        logic [LW-1:0]   lane;
        logic [VLEN-1:0] pc;
    } monitor_ctrl_t;

    logic [NUM_LANES-1:0]  alloc;
    logic [VLEN-1:0]       pc_mem [NUM_LANES];
    logic [AW-1:0]         age [NUM_LANES];
    logic [LW-1:0]         rr_ptr;
    logic [DROP_CNT_W-1:0] drop_cnt;

    lane_ctrl_t           ev;
    logic [NUM_LANES-1:0] rel_hit;
    logic [NUM_LANES-1:0] avail;
    logic [NUM_LANES-1:0] expire;
    logic                 mon_req;
    logic                 grant_found;
    logic [LW-1:0]        grant_lane;
    logic [LW-1:0]        grant_start;
    logic                 grant;
    logic                 full;
    monitor_ctrl_t        mon;
    logic                 unused_pc_fold;

    always_comb begin
        rel_hit = '0;
        ev      = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            ev = rel_i[i*(LW+1) +: (LW+1)];
            if (ev.reset_lane && int'(ev.lane) < NUM_LANES) begin
                rel_hit[ev.lane] = 1'b1;
            end
        end
    end

    assign mon_req     = entry_queued_i & opcode_class_en(opcode_i, cfg_class_en_i) & ~flush_i;
    // A lane being released this cycle can be handed straight to the new instruction.
    assign avail       = ~alloc | rel_hit;
    assign grant_start = (ALLOC_POLICY != 0) ? rr_ptr : '0;

    rm_lane_manager_picker #(
        .N (NUM_LANES)
    ) u_grant_pick (
        .avail (avail),
        .start (grant_start),
        .found (grant_found),
        .idx   (grant_lane)
    );

    assign grant   = mon_req & grant_found;
    assign full    = mon_req & ~grant_found;
    assign stall_o = (FULL_MODE == 0) & full;
    assign drop_o  = (FULL_MODE != 0) & full;

    always_comb begin
        mon             = '0;
        mon.monitor_ins = grant;
        mon.lane        = grant ? grant_lane : '0;
        mon.pc          = pc_i;
    end
    assign monitor_o = mon;

    // Released or re-granted lanes never count as timed out.
    always_comb begin
        expire = '0;
        if (TIMEOUT > 0) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                expire[l] = alloc[l] && (age[l] == AGE_LAST) && !rel_hit[l]
                            && !(grant && (grant_lane == LW'(l)));
            end
        end
    end

    rm_lane_manager_picker #(
        .N (NUM_LANES)
    ) u_wd_pick (
        .avail (expire),
        .start ('0),
        .found (timeout_o),
        .idx   (timeout_lane_o)
    );

    assign occupancy_o = OW'($countones(alloc));
    assign drop_cnt_o  = drop_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            alloc    <= '0;
            rr_ptr   <= '0;
            drop_cnt <= '0;
            for (int l = 0; l < NUM_LANES; l++) begin
                pc_mem[l] <= '0;
                age[l]    <= '0;
            end
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (grant && (grant_lane == LW'(l))) begin
                    alloc[l]  <= 1'b1;
                    pc_mem[l] <= pc_i;
                    age[l]    <= '0;
                end else if (rel_hit[l] || expire[l]) begin
                    alloc[l] <= 1'b0;
                    age[l]   <= '0;
                end else if (alloc[l] && (TIMEOUT > 0)) begin
                    age[l] <= age[l] + 1'b1;
                end
            end
            if (grant) begin
                rr_ptr <= (int'(grant_lane) == NUM_LANES - 1) ? '0 : grant_lane + 1'b1;
            end
            if (drop_o && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    // Owner PCs have no output port; they are inspected through hierarchy.
    always_comb begin
        unused_pc_fold = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            unused_pc_fold = unused_pc_fold ^ (^pc_mem[l]);
        end
    end

endmodule

// File: tb/tb_rm_lane_manager.sv
// Drives four differently configured allocators with shared stimulus and
// checks them against a lane-table model of the allocation rules.
module tb_rm_lane_manager;
    import rm_lane_manager_pkg::*;

    localparam int NI = 4;
    localparam int NL = 4;
    localparam int NE = 10;
    localparam int LW = 2;
    localparam int RW = NE * (LW + 1);

    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n  = 1'b0;
    logic [6:0]      opcode = OP_ALU;
    logic [VLEN-1:0] pc     = '0;
    logic            queued = 1'b0;
    logic            flush  = 1'b0;
    logic [3:0]      cls_en = 4'hF;
    logic [RW-1:0]   rel    = '0;

    logic [LW+VLEN:0] mon      [NI];
    logic             stall    [NI];
    logic             drop     [NI];
    logic             tmo      [NI];
    logic [LW-1:0]    tmo_lane [NI];
    logic [2:0]       occ      [NI];
    logic [15:0]      dcnt     [NI];

    // g0: lowest/stall/T8, g1: round-robin/stall/T8, g2: lowest/drop/no watchdog/3-bit count, g3: round-robin/drop/T16
    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DW = (g == 2) ? 3 : 16;
        logic [DW-1:0] dc;
        rm_lane_manager #(
            .NUM_LANES    (NL),
            .NUM_EVENTS   (NE),
            .ALLOC_POLICY (g % 2),
            .FULL_MODE    (g / 2),
            .TIMEOUT      ((g < 2) ? 8 : ((g == 2) ? 0 : 16)),
            .DROP_CNT_W   (DW)
        ) u_dut (
            .clk_i          (clk),
            .rst_ni         (rst_n),
            .opcode_i       (opcode),
            .pc_i           (pc),
            .entry_queued_i (queued),
            .flush_i        (flush),
            .cfg_class_en_i (cls_en),
            .rel_i          (rel),
            .monitor_o      (mon[g]),
            .stall_o        (stall[g]),
            .drop_o         (drop[g]),
            .timeout_o      (tmo[g]),
            .timeout_lane_o (tmo_lane[g]),
            .occupancy_o    (occ[g]),
            .drop_cnt_o     (dc)
        );
        assign dcnt[g] = 16'(dc);
    end

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: per-instance lane table.
    bit              m_alloc [NI][NL];
    logic [VLEN-1:0] m_pc    [NI][NL];
    int              m_age   [NI][NL];
    int              m_rr    [NI];
    int              m_dc    [NI];
    bit              m_hit   [NL];
    bit              m_exp   [NI][NL];
    bit e_ins [NI]; int e_lane [NI]; bit e_stall [NI]; bit e_drop [NI];
    bit e_to  [NI]; int e_tol  [NI]; int e_occ   [NI];

    function automatic int pol(input int g);   return g % 2; endfunction
    function automatic int fullm(input int g); return g / 2; endfunction
    function automatic int to_of(input int g); return (g < 2) ? 8 : ((g == 2) ? 0 : 16); endfunction
    function automatic int dmax(input int g);  return (g == 2) ? 7 : 65535; endfunction

    function automatic bit class_on(input logic [6:0] op, input logic [3:0] en);
        if (op == OP_ST) return en[0];
        if (op == OP_LD) return en[1];
        if (op == OP_BR) return en[2];
        if (op == OP_JAL || op == OP_JALR) return en[3];
        return 1'b0;
    endfunction

    function automatic bit m_ins(input int g);  return mon[g][LW+VLEN]; endfunction
    function automatic int m_lane(input int g); return int'(mon[g][VLEN +: LW]); endfunction

    task automatic model_eval();
        bit req;
        int st;
        int l;
        req = queued && !flush && class_on(opcode, cls_en);
        for (int k = 0; k < NL; k++) m_hit[k] = 1'b0;
        for (int i = 0; i < NE; i++)
            if (rel[i*(LW+1)+LW]) m_hit[rel[i*(LW+1) +: LW]] = 1'b1;
        for (int g = 0; g < NI; g++) begin
            e_occ[g] = 0;
            for (int k = 0; k < NL; k++) e_occ[g] += int'(m_alloc[g][k]);
            e_ins[g]  = 1'b0;
            e_lane[g] = 0;
            st = (pol(g) == 1) ? m_rr[g] : 0;
            if (req) begin
                for (int k = 0; k < NL; k++) begin
                    l = (st + k) % NL;
                    if (!e_ins[g] && (!m_alloc[g][l] || m_hit[l])) begin
                        e_ins[g]  = 1'b1;
                        e_lane[g] = l;
                    end
                end
            end
            e_stall[g] = req && !e_ins[g] && fullm(g) == 0;
            e_drop[g]  = req && !e_ins[g] && fullm(g) == 1;
            e_to[g]  = 1'b0;
            e_tol[g] = 0;
            for (int k = 0; k < NL; k++) begin
                m_exp[g][k] = to_of(g) > 0 && m_alloc[g][k] && m_age[g][k] == to_of(g) - 1
                              && !m_hit[k] && !(e_ins[g] && e_lane[g] == k);
                if (m_exp[g][k] && !e_to[g]) begin
                    e_to[g]  = 1'b1;
                    e_tol[g] = k;
                end
            end
        end
    endtask

    task automatic model_commit();
        for (int g = 0; g < NI; g++) begin
            if (!rst_n) begin
                for (int k = 0; k < NL; k++) begin
                    m_alloc[g][k] = 1'b0; m_age[g][k] = 0; m_pc[g][k] = '0;
                end
                m_rr[g] = 0;
                m_dc[g] = 0;
            end else begin
                for (int k = 0; k < NL; k++) begin
                    if (e_ins[g] && e_lane[g] == k) begin
                        m_alloc[g][k] = 1'b1; m_pc[g][k] = pc; m_age[g][k] = 0;
                    end else if (m_hit[k] || m_exp[g][k]) begin
                        m_alloc[g][k] = 1'b0; m_age[g][k] = 0;
                    end else if (m_alloc[g][k] && to_of(g) > 0) begin
                        m_age[g][k]++;
                    end
                end
                if (e_ins[g]) m_rr[g] = (e_lane[g] + 1) % NL;
                if (e_drop[g] && m_dc[g] < dmax(g)) m_dc[g]++;
            end
        end
    endtask

    task automatic idle();
        queued = 1'b0; flush = 1'b0; rel = '0; opcode = OP_ALU;
    endtask
    task automatic issue(input logic [6:0] op);
        queued = 1'b1; opcode = op; pc = {$urandom, $urandom};
    endtask
    task automatic set_rel(input int slot, input int lane);
        rel[slot*(LW+1) +: (LW+1)] = {1'b1, LW'(lane)};
    endtask
    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask
    task automatic advance();
        model_commit();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0; idle(); settle(); advance(); rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cls_en = 4'hF; do_reset(); idle(); settle();
        for (int g = 0; g < NI; g++) begin
            n_vec++; if (occ[g] !== 3'd0) begin n_bad++; $display("FAIL reset_occ[%0d] got %0d want 0", g, occ[g]); end
            n_vec++; if (stall[g] !== 1'b0 || drop[g] !== 1'b0) begin n_bad++; $display("FAIL reset_stall_drop[%0d] got %b%b want 00", g, stall[g], drop[g]); end
            n_vec++; if (tmo[g] !== 1'b0) begin n_bad++; $display("FAIL reset_timeout[%0d] got %b want 0", g, tmo[g]); end
            n_vec++; if (dcnt[g] !== 16'd0) begin n_bad++; $display("FAIL reset_dropcnt[%0d] got %0d want 0", g, dcnt[g]); end
        end
        advance();
    endtask

    task automatic test_fill_stall();
        cls_en = 4'hF; do_reset();
        for (int k = 0; k < 4; k++) begin
            idle(); issue(OP_ST); settle();
            n_vec++; if (m_ins(0) !== 1'b1 || m_lane(0) != k) begin n_bad++; $display("FAIL fill_grant%0d got ins=%b lane=%0d want ins=1 lane=%0d", k, m_ins(0), m_lane(0), k); end
            n_vec++; if (mon[0][VLEN-1:0] !== pc) begin n_bad++; $display("FAIL fill_pc%0d got %h want %h", k, mon[0][VLEN-1:0], pc); end
            advance();
        end
        idle(); settle();
        n_vec++; if (occ[0] !== 3'd4) begin n_bad++; $display("FAIL fill_occ got %0d want 4", occ[0]); end
        advance();
        idle(); issue(OP_ST); settle();
        n_vec++; if (stall[0] !== 1'b1 || m_ins(0) !== 1'b0) begin n_bad++; $display("FAIL full_stall got stall=%b ins=%b want 1 0", stall[0], m_ins(0)); end
        n_vec++; if (drop[2] !== 1'b1 || stall[2] !== 1'b0) begin n_bad++; $display("FAIL full_dropmode got drop=%b stall=%b want 1 0", drop[2], stall[2]); end
        advance();
    endtask

    task automatic test_release_bypass();
        idle(); issue(OP_ST); set_rel(3, 2); settle();
        n_vec++; if (m_ins(0) !== 1'b1 || m_lane(0) != 2 || stall[0] !== 1'b0) begin n_bad++; $display("FAIL bypass got ins=%b lane=%0d stall=%b want 1 2 0", m_ins(0), m_lane(0), stall[0]); end
        advance();
        idle(); settle();
        n_vec++; if (occ[0] !== 3'd4) begin n_bad++; $display("FAIL bypass_occ got %0d want 4", occ[0]); end
        n_vec++; if (g_dut[0].u_dut.pc_mem[2] !== m_pc[0][2]) begin n_bad++; $display("FAIL bypass_pc got %h want %h", g_dut[0].u_dut.pc_mem[2], m_pc[0][2]); end
        advance();
    endtask

    task automatic test_drop();
        cls_en = 4'hF; do_reset();
        for (int k = 0; k < 4; k++) begin idle(); issue(OP_ST); settle(); advance(); end
        cls_en = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            idle(); issue(OP_LD); settle();
            n_vec++; if (drop[2] !== 1'b1 || m_ins(2) !== 1'b0) begin n_bad++; $display("FAIL drop_load%0d got drop=%b ins=%b want 1 0", k, drop[2], m_ins(2)); end
            advance();
        end
        idle(); issue(OP_BR); settle();
        n_vec++; if (drop[2] !== 1'b0 || m_ins(2) !== 1'b0 || stall[0] !== 1'b0) begin n_bad++; $display("FAIL branch_disabled got drop=%b ins=%b stall=%b want 000", drop[2], m_ins(2), stall[0]); end
        n_vec++; if (dcnt[2] !== 16'd3 || dcnt[3] !== 16'd3) begin n_bad++; $display("FAIL drop_cnt3 got %0d %0d want 3 3", dcnt[2], dcnt[3]); end
        advance();
        for (int k = 0; k < 6; k++) begin idle(); issue(OP_LD); settle(); advance(); end
        idle(); settle();
        n_vec++; if (dcnt[2] !== 16'd7) begin n_bad++; $display("FAIL drop_saturate got %0d want 7", dcnt[2]); end
        n_vec++; if (dcnt[3] !== 16'd9) begin n_bad++; $display("FAIL drop_cnt9 got %0d want 9", dcnt[3]); end
        advance();
        cls_en = 4'hF;
    endtask

    task automatic test_round_robin();
        int want [4];
        cls_en = 4'hF; do_reset();
        want = '{0, 1, 2, 3};
        for (int k = 0; k < 2; k++) begin
            idle(); issue(OP_ST); settle();
            n_vec++; if (m_ins(1) !== 1'b1 || m_lane(1) != want[k]) begin n_bad++; $display("FAIL rr_grant%0d got lane=%0d want %0d", k, m_lane(1), want[k]); end
            advance();
        end
        idle(); set_rel(0, 0); settle(); advance();
        idle(); issue(OP_ST); settle();
        n_vec++; if (m_lane(1) != 2) begin n_bad++; $display("FAIL rr_skip got lane=%0d want 2", m_lane(1)); end
        n_vec++; if (m_lane(0) != 0) begin n_bad++; $display("FAIL lowest_reuse got lane=%0d want 0", m_lane(0)); end
        advance();
        idle(); issue(OP_ST); settle();
        n_vec++; if (m_lane(1) != 3) begin n_bad++; $display("FAIL rr_lane3 got lane=%0d want 3", m_lane(1)); end
        advance();
        idle(); issue(OP_ST); settle();
        n_vec++; if (m_ins(1) !== 1'b1 || m_lane(1) != 0) begin n_bad++; $display("FAIL rr_wrap got ins=%b lane=%0d want 1 0", m_ins(1), m_lane(1)); end
        advance();
    endtask

    task automatic test_timeout();
        cls_en = 4'hF; do_reset();
        idle(); issue(OP_ST); settle();
        n_vec++; if (m_ins(0) !== 1'b1 || m_lane(0) != 0) begin n_bad++; $display("FAIL wd_grant got ins=%b lane=%0d want 1 0", m_ins(0), m_lane(0)); end
        advance();
        for (int c = 1; c <= 8; c++) begin
            idle(); settle();
            if (c < 8) begin
                n_vec++; if (tmo[0] !== 1'b0) begin n_bad++; $display("FAIL wd_early%0d got %b want 0", c, tmo[0]); end
            end else begin
                n_vec++; if (tmo[0] !== 1'b1 || tmo_lane[0] !== 2'd0) begin n_bad++; $display("FAIL wd_fire got tmo=%b lane=%0d want 1 0", tmo[0], tmo_lane[0]); end
            end
            advance();
        end
        idle(); settle();
        n_vec++; if (occ[0] !== 3'd0) begin n_bad++; $display("FAIL wd_occ got %0d want 0", occ[0]); end
        n_vec++; if (occ[2] !== 3'd1 || occ[3] !== 3'd1) begin n_bad++; $display("FAIL wd_other_occ got %0d %0d want 1 1", occ[2], occ[3]); end
        advance();
    endtask

    task automatic test_flush();
        cls_en = 4'hF; do_reset();
        for (int k = 0; k < 2; k++) begin idle(); issue(OP_ST); settle(); advance(); end
        idle(); issue(OP_ST); flush = 1'b1; set_rel(5, 0); settle();
        n_vec++; if (m_ins(0) !== 1'b0 || m_lane(0) != 0 || stall[0] !== 1'b0) begin n_bad++; $display("FAIL flush_block got ins=%b lane=%0d stall=%b want 0 0 0", m_ins(0), m_lane(0), stall[0]); end
        advance();
        idle(); settle();
        n_vec++; if (occ[0] !== 3'd1) begin n_bad++; $display("FAIL flush_release got occ=%0d want 1", occ[0]); end
        advance();
        for (int k = 0; k < 3; k++) begin idle(); issue(OP_ST); settle(); advance(); end
        idle(); settle();
        n_vec++; if (occ[0] !== 3'd4) begin n_bad++; $display("FAIL refill_occ got %0d want 4", occ[0]); end
        advance();
        rst_n = 1'b0; issue(OP_ST); settle(); advance();
        rst_n = 1'b1; idle(); settle();
        n_vec++; if (occ[0] !== 3'd0 || occ[1] !== 3'd0) begin n_bad++; $display("FAIL midreset_occ got %0d %0d want 0 0", occ[0], occ[1]); end
        advance();
    endtask

    task automatic test_random();
        cls_en = 4'hF; do_reset();
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst_n  = ($urandom_range(0, 199) != 0);
            queued = ($urandom_range(0, 9) < 7);
            flush  = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 5))
                0: opcode = OP_ST;
                1: opcode = OP_LD;
                2: opcode = OP_BR;
                3: opcode = OP_JAL;
                4: opcode = OP_JALR;
                default: opcode = OP_ALU;
            endcase
            pc     = {$urandom, $urandom};
            cls_en = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            for (int i = 0; i < NE; i++)
                if ($urandom_range(0, 29) == 0) set_rel(i, int'($urandom_range(0, 3)));
            settle();
            for (int g = 0; g < NI; g++) begin
                n_vec++; if (m_ins(g) !== e_ins[g]) begin n_bad++; $display("FAIL rnd_ins[%0d] c%0d got %b want %b", g, c, m_ins(g), e_ins[g]); end
                n_vec++; if (m_lane(g) != e_lane[g]) begin n_bad++; $display("FAIL rnd_lane[%0d] c%0d got %0d want %0d", g, c, m_lane(g), e_lane[g]); end
                n_vec++; if (mon[g][VLEN-1:0] !== pc) begin n_bad++; $display("FAIL rnd_pc[%0d] c%0d got %h want %h", g, c, mon[g][VLEN-1:0], pc); end
                n_vec++; if (stall[g] !== e_stall[g]) begin n_bad++; $display("FAIL rnd_stall[%0d] c%0d got %b want %b", g, c, stall[g], e_stall[g]); end
                n_vec++; if (drop[g] !== e_drop[g]) begin n_bad++; $display("FAIL rnd_drop[%0d] c%0d got %b want %b", g, c, drop[g], e_drop[g]); end
                n_vec++; if (tmo[g] !== e_to[g]) begin n_bad++; $display("FAIL rnd_timeout[%0d] c%0d got %b want %b", g, c, tmo[g], e_to[g]); end
                if (e_to[g]) begin
                    n_vec++; if (tmo_lane[g] !== LW'(e_tol[g])) begin n_bad++; $display("FAIL rnd_tlane[%0d] c%0d got %0d want %0d", g, c, tmo_lane[g], e_tol[g]); end
                end
                n_vec++; if (occ[g] !== 3'(e_occ[g])) begin n_bad++; $display("FAIL rnd_occ[%0d] c%0d got %0d want %0d", g, c, occ[g], e_occ[g]); end
                n_vec++; if (dcnt[g] !== 16'(m_dc[g])) begin n_bad++; $display("FAIL rnd_dropcnt[%0d] c%0d got %0d want %0d", g, c, dcnt[g], m_dc[g]); end
            end
            advance();
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill_stall();
        test_release_bypass();
        test_drop();
        test_round_robin();
        test_timeout();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
